// File: rtl/palette_dac_pkg.sv
// Shared definitions for the palette DAC: write-FSM states, palette entry
// layout and the 3-bit / 2-bit to 4-bit colour expansion helpers.
package palette_dac_pkg;

  localparam int unsigned PAL_DEPTH = 16;

  typedef enum logic {
    WR_IDLE,
    WR_PEND
  } wr_state_t;

  // Palette byte layout as written by the CPU: {B[1:0], G[2:0], R[2:0]}
  typedef struct packed {
    logic [1:0] b;
    logic [2:0] g;
    logic [2:0] r;
  } pal_entry_t;

  // Replicate the MSB so that full scale maps to 4'hF and zero stays zero
  function automatic logic [3:0] expand3(input logic [2:0] c);
    return {c, c[2]};
  endfunction

  function automatic logic [3:0] expand2(input logic [1:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/palette_dac_regs.sv
// palette_regs: 16 x 8 palette register file.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (clears all entries)
//   we/waddr/wdata single write port, written on the clock edge
//   raddr/rdata    combinational read port (a same-cycle write is not yet visible)
module palette_regs
  import palette_dac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [PAL_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PAL_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/palette_dac.sv
// palette_dac: resolves the 4-bit colour index (or border index) through a
// CPU-writable 16-entry palette into 4-bit-per-channel RGB, with syncs and
// blanking delayed to stay aligned with the pixel data (2 clk24 latency).
// CPU palette writes are held pending and committed only in a write window.
// Ports:
//   clk24, reset                 24 MHz clock, async active-high reset
//   ce12                         12 MHz pixel clock enable (gates commits only)
//   coloridx, border, border_idx pixel index / border select / border index
//   video_active                 1 = visible raster (0 = blanked)
//   hsync_in, vsync_in           active-low syncs from the video stage
//   pal_wr_req/idx/data          single-cycle CPU palette write
//   pal_wr_busy                  1 while a write is pending
//   r, g, b, hsync, vsync        aligned DAC outputs
module palette_dac
  import palette_dac_pkg::*;
#(
  parameter bit         WR_RETRACE_ONLY = 1'b1,
  parameter logic [3:0] BLANK_LEVEL     = 4'h0
) (
  input  logic       clk24,
  input  logic       reset,
  input  logic       ce12,
  input  logic [3:0] coloridx,
  input  logic       border,
  input  logic [3:0] border_idx,
  input  logic       video_active,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pal_wr_req,
  input  logic [3:0] pal_wr_idx,
  input  logic [7:0] pal_wr_data,
  output logic       pal_wr_busy,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       hsync,
  output logic       vsync
);

  wr_state_t  state, state_next;
  logic       commit;
  logic [3:0] pend_idx;
  logic [7:0] pend_data;

  logic [3:0] s1_idx;
  logic       s1_blank;
  logic       s1_hsync;
  logic       s1_vsync;

  logic [7:0] pal_rdata;
  pal_entry_t entry;

  palette_regs u_regs (
    .clk   (clk24),
    .rst   (reset),
    .we    (commit),
    .waddr (pend_idx),
    .wdata (pend_data),
    .raddr (s1_idx),
    .rdata (pal_rdata)
  );

  // Write FSM: a request arriving in the commit cycle re-arms PEND with the
  // new entry while the old one is written.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    unique case (state)
      WR_IDLE: begin
        if (pal_wr_req) state_next = WR_PEND;
      end
      WR_PEND: begin
        commit = ce12 && (!WR_RETRACE_ONLY || !video_active);
        if (commit && !pal_wr_req) state_next = WR_IDLE;
      end
      default: state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      state     <= WR_IDLE;
      pend_idx  <= '0;
      pend_data <= '0;
    end else begin
      state <= state_next;
      // Latest request always wins; the commit above uses the old values
      if (pal_wr_req) begin
        pend_idx  <= pal_wr_idx;
        pend_data <= pal_wr_data;
      end
    end
  end

  assign pal_wr_busy = (state == WR_PEND);

  // S1: index select and sync/blank capture
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      s1_idx   <= '0;
      s1_blank <= 1'b1;
      s1_hsync <= 1'b1;
      s1_vsync <= 1'b1;
    end else begin
      s1_idx   <= border ? border_idx : coloridx;
      s1_blank <= !video_active;
      s1_hsync <= hsync_in;
      s1_vsync <= vsync_in;
    end
  end

  assign entry = pal_entry_t'(pal_rdata);

  // S2: palette lookup, expansion and blanking
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      r     <= BLANK_LEVEL;
      g     <= BLANK_LEVEL;
      b     <= BLANK_LEVEL;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      r     <= s1_blank ? BLANK_LEVEL : expand3(entry.r);
      g     <= s1_blank ? BLANK_LEVEL : expand3(entry.g);
      b     <= s1_blank ? BLANK_LEVEL : expand2(entry.b);
      hsync <= s1_hsync;
      vsync <= s1_vsync;
    end
  end

endmodule

// File: tb/tb_palette_dac.sv
// Testbench for palette_dac: directed scenarios followed by random traffic.
// The driver keeps a behavioural palette model and pushes the expected output
// for each clock into a queue; an independent monitor pops and compares.
module tb_palette_dac;

  localparam bit         WRO   = 1'b1;
  localparam logic [3:0] BLANK = 4'h0;

  logic       clk24 = 1'b0;
  logic       reset;
  logic       ce12;
  logic [3:0] coloridx;
  logic       border;
  logic [3:0] border_idx;
  logic       video_active;
  logic       hsync_in;
  logic       vsync_in;
  logic       pal_wr_req;
  logic [3:0] pal_wr_idx;
  logic [7:0] pal_wr_data;
  logic       pal_wr_busy;
  logic [3:0] r, g, b;
  logic       hsync, vsync;

  palette_dac #(
    .WR_RETRACE_ONLY (WRO),
    .BLANK_LEVEL     (BLANK)
  ) dut (
    .clk24        (clk24),
    .reset        (reset),
    .ce12         (ce12),
    .coloridx     (coloridx),
    .border       (border),
    .border_idx   (border_idx),
    .video_active (video_active),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .pal_wr_req   (pal_wr_req),
    .pal_wr_idx   (pal_wr_idx),
    .pal_wr_data  (pal_wr_data),
    .pal_wr_busy  (pal_wr_busy),
    .r            (r),
    .g            (g),
    .b            (b),
    .hsync        (hsync),
    .vsync        (vsync)
  );

  always #5 clk24 = ~clk24;

  typedef struct {
    int r, g, b, hs, vs, busy;
  } exp_t;

  typedef struct {
    int idx;
    bit blank;
    bit hs, vs;
  } sample_t;

  exp_t    sb[$];
  bit      running = 1'b0;
  int      n_checks = 0;
  int      n_fail = 0;
  bit      rand_ce = 1'b0;

  // Reference model state
  int      mdl_pal [16];
  bit      m_pend;
  int      m_pidx, m_pdata;
  sample_t m_prev;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Channel expansion from the palette byte, by arithmetic
  function automatic exp_t colour_of(input sample_t s);
    exp_t e;
    int v, rv, gv, bv;
    if (s.blank) begin
      e.r = BLANK; e.g = BLANK; e.b = BLANK;
    end else begin
      v  = mdl_pal[s.idx];
      rv = v % 8;
      gv = (v / 8) % 8;
      bv = v / 64;
      e.r = rv * 2 + rv / 4;
      e.g = gv * 2 + gv / 4;
      e.b = bv * 5;
    end
    e.hs = s.hs;
    e.vs = s.vs;
    e.busy = 0;
    return e;
  endfunction

  // Model one clock edge with the current inputs, queue the expected output,
  // then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    if (reset) begin
      for (int i = 0; i < 16; i++) mdl_pal[i] = 0;
      m_pend = 1'b0;
      m_prev = '{idx: 0, blank: 1'b1, hs: 1'b1, vs: 1'b1};
      e = '{r: BLANK, g: BLANK, b: BLANK, hs: 1, vs: 1, busy: 0};
    end else begin
      e = colour_of(m_prev);
      if (m_pend && ce12 && (!WRO || !video_active)) begin
        mdl_pal[m_pidx] = m_pdata;
        m_pend = 1'b0;
      end
      if (pal_wr_req) begin
        m_pend  = 1'b1;
        m_pidx  = pal_wr_idx;
        m_pdata = pal_wr_data;
      end
      e.busy = m_pend;
      m_prev = '{idx: border ? int'(border_idx) : int'(coloridx),
                 blank: !video_active, hs: hsync_in, vs: vsync_in};
    end
    sb.push_back(e);
    running = 1'b1;
    @(negedge clk24);
    ce12 = rand_ce ? 1'($urandom_range(1)) : ~ce12;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_write(input logic [3:0] idx, input logic [7:0] data);
    pal_wr_req  = 1'b1;
    pal_wr_idx  = idx;
    pal_wr_data = data;
    tick();
    pal_wr_req  = 1'b0;
  endtask

  // Monitor: outputs are valid every clock, sampled just after the edge
  always begin
    exp_t e;
    @(posedge clk24);
    #1;
    if (running) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow at %0t: got 0 entries expected 1", $time);
      end else begin
        e = sb.pop_front();
        chk("r", int'(r), e.r);
        chk("g", int'(g), e.g);
        chk("b", int'(b), e.b);
        chk("hsync", int'(hsync), e.hs);
        chk("vsync", int'(vsync), e.vs);
        chk("busy", int'(pal_wr_busy), e.busy);
      end
    end
  end

  initial begin
    reset = 1'b1; ce12 = 1'b0; coloridx = '0; border = 1'b0; border_idx = '0;
    video_active = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    pal_wr_req = 1'b0; pal_wr_idx = '0; pal_wr_data = '0;

    // Reset state
    @(posedge clk24);
    #1;
    chk("rst_r", int'(r), BLANK);
    chk("rst_g", int'(g), BLANK);
    chk("rst_b", int'(b), BLANK);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_busy", int'(pal_wr_busy), 0);
    @(negedge clk24);
    idle(2);
    reset = 1'b0;

    // 1: empty palette gives black
    coloridx = 4'd3; video_active = 1'b1; border = 1'b0;
    idle(4);

    // 2: write held off during active video, commits in retrace
    cpu_write(4'd5, 8'hC7);
    idle(6);
    video_active = 1'b0;
    idle(2);
    video_active = 1'b1; coloridx = 4'd5;
    idle(4);

    // 3: last pending write wins
    cpu_write(4'd2, 8'h01);
    cpu_write(4'd2, 8'h38);
    idle(2);
    video_active = 1'b0;
    idle(2);
    video_active = 1'b1; coloridx = 4'd2;
    idle(4);

    // 4: border priority, blanking priority over border
    video_active = 1'b0;
    cpu_write(4'd9, 8'h07);
    idle(2);
    video_active = 1'b1; border = 1'b1; border_idx = 4'd9; coloridx = 4'd0;
    idle(4);
    video_active = 1'b0;
    idle(4);
    border = 1'b0; video_active = 1'b1;

    // 5: long hsync pulse
    coloridx = 4'd5;
    hsync_in = 1'b0;
    idle(56);
    hsync_in = 1'b1;
    idle(4);

    // 6: reset while a write is pending
    cpu_write(4'd1, 8'hFF);
    idle(2);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    coloridx = 4'd1;
    idle(2);
    video_active = 1'b0;
    idle(2);
    video_active = 1'b1;
    idle(3);

    // Random traffic, including commit/request collisions and resets
    rand_ce = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      coloridx     = 4'($urandom);
      border       = ($urandom_range(3) == 0);
      border_idx   = 4'($urandom);
      video_active = ($urandom_range(3) != 0);
      hsync_in     = ($urandom_range(7) != 0);
      vsync_in     = ($urandom_range(15) != 0);
      pal_wr_req   = ($urandom_range(4) == 0);
      pal_wr_idx   = 4'($urandom);
      pal_wr_data  = 8'($urandom);
      reset        = ($urandom_range(499) == 0);
      tick();
    end
    reset = 1'b0; pal_wr_req = 1'b0;
    idle(2);

    running = 1'b0;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
